// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state type and default link geometry for the TDM operand link
package tdm_pkg;
  localparam int TDM_W = 8;
  localparam int TDM_N = 4;
  typedef enum logic {IDLE, RUN} tdm_state_t;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial slot input and parallel frame bank output of the TDM receiver
interface tdm_demux_if import tdm_pkg::*; #(parameter int W = TDM_W, parameter int N = TDM_N) ();
  logic in_valid;
  logic in_sof;
  logic [W-1:0] in_data;
  logic [N*W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic frame_err;
  logic overrun;
  modport master(output in_valid, in_sof, in_data, out_ready, input out_data, out_valid, frame_err, overrun);
  modport slave(input in_valid, in_sof, in_data, out_ready, output out_data, out_valid, frame_err, overrun);
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index with clear, load-to-1 and increment; flags the last slot
module tdm_slot_counter #(parameter int N = 4, parameter int SW = $clog2(N)) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          inc_i,
  output logic [SW-1:0] cnt_o,
  output logic          last_o
);
  logic [SW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : load_i ? SW'(1) : inc_i ? cnt_q + SW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == SW'(N - 1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: routes serial slot words into a shadow bank and commits whole frames
// to a valid/ready parallel output, flagging mid-frame restarts and unconsumed overwrites.
module tdm_demux import tdm_pkg::*; #(parameter int W = TDM_W, parameter int N = TDM_N) (
  input logic        clk,
  input logic        rst,
  tdm_demux_if.slave bus
);
  localparam int SW = $clog2(N);
  tdm_state_t state_q, state_d;
  logic [N-2:0][W-1:0] shadow_q, shadow_d;
  logic [N*W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;
  logic [SW-1:0] slot;
  logic last, sof_v, dat_v, commit;
  assign sof_v  = bus.in_valid & bus.in_sof;
  assign dat_v  = bus.in_valid & ~bus.in_sof & (state_q == RUN);
  assign commit = dat_v & last;
  tdm_slot_counter #(.N(N), .SW(SW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (commit),
    .load_i(sof_v),
    .inc_i (dat_v & ~last),
    .cnt_o (slot),
    .last_o(last)
  );
  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    shadow_d    = shadow_q;
    if (sof_v) begin
      state_d     = RUN;
      frame_err_d = state_q == RUN;
      shadow_d[0] = bus.in_data;
    end else if (commit) begin
      state_d = IDLE;
    end else if (dat_v) begin
      shadow_d[slot] = bus.in_data;
    end
  end
  // the final slot bypasses the shadow bank so the frame lands one cycle after its last word
  always_comb begin
    out_data_d  = commit ? {bus.in_data, shadow_q} : out_data_q;
    out_valid_d = commit | (out_valid_q & ~bus.out_ready);
    overrun_d   = commit & out_valid_q & ~bus.out_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule
